// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin share of one async-read/sync-write RAM port between M0 (fetch)
// and M1 (load/store); byte strobes via read-modify-write. Optional counters: ARB_PERF_CNT_EN.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int PERF_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_req,
  input  logic                    m0_wr,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic                    m0_gnt,
  output logic                    m0_rsp_valid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_wr,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic                    m1_gnt,
  output logic                    m1_rsp_valid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_a,
  output logic [DATA_WIDTH-1:0]   ram_d,
  output logic                    ram_we,
  input  logic [DATA_WIDTH-1:0]   ram_spo,
  output logic [PERF_W-1:0]       perf_gnt0,
  output logic [PERF_W-1:0]       perf_gnt1,
  output logic [PERF_W-1:0]       perf_conflict
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_WR, S_RSP} state_t;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_rr_last;
  logic                  r_wr;
  logic [STRB_W-1:0]     r_strb;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_merge;

  logic                  w_idle;
  logic                  w_pick0;
  logic                  w_pick1;
  logic                  w_full;
  logic                  w_none;
  logic                  w_acc_full_wr;
  logic                  w_wr_state;
  logic                  w_rsp;
  logic [DATA_WIDTH-1:0] w_merge;

  // On conflict the master that did not win last time is chosen.
  assign w_pick0 = m0_req & (~m1_req | r_rr_last);
  assign w_pick1 = m1_req & (~m0_req | ~r_rr_last);
  assign w_idle  = (r_state == S_IDLE) & ~reset;
  assign m0_gnt  = w_idle & w_pick0;
  assign m1_gnt  = w_idle & w_pick1;

  assign w_full = &r_strb;
  assign w_none = ~|r_strb;

  always_comb begin
    w_merge = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      w_merge[8*i +: 8] = r_strb[i] ? r_wdata[8*i +: 8] : ram_spo[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b0;
      r_wr      <= 1'b0;
      r_strb    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_merge   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick0 | w_pick1) begin
            r_owner   <= w_pick1;
            r_rr_last <= w_pick1;
            r_wr      <= w_pick1 ? m1_wr    : m0_wr;
            r_strb    <= w_pick1 ? m1_wstrb : m0_wstrb;
            r_addr    <= w_pick1 ? m1_addr  : m0_addr;
            r_wdata   <= w_pick1 ? m1_wdata : m0_wdata;
            r_state   <= S_ACC;
          end
        end
        S_ACC: begin
          if (!r_wr) begin
            r_rdata <= ram_spo;
            r_state <= S_RSP;
          end else if (w_full || w_none) begin
            r_state <= S_RSP;
          end else begin
            r_merge <= w_merge;
            r_state <= S_WR;
          end
        end
        S_WR:    r_state <= S_RSP;
        S_RSP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM-side strobes are decoded from state so that reset can veto a write in the same cycle.
  assign w_acc_full_wr = (r_state == S_ACC) & r_wr & w_full;
  assign w_wr_state    = (r_state == S_WR);
  assign ram_a         = r_addr;
  assign ram_we        = (w_acc_full_wr | w_wr_state) & ~reset;
  assign ram_d         = w_acc_full_wr ? r_wdata : (w_wr_state ? r_merge : '0);

  assign w_rsp        = (r_state == S_RSP) & ~reset;
  assign m0_rsp_valid = w_rsp & ~r_owner;
  assign m1_rsp_valid = w_rsp & r_owner;
  assign m0_rdata     = (m0_rsp_valid & ~r_wr) ? r_rdata : '0;
  assign m1_rdata     = (m1_rsp_valid & ~r_wr) ? r_rdata : '0;

`ifdef ARB_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_gnt0;
  logic [PERF_W-1:0] r_perf_gnt1;
  logic [PERF_W-1:0] r_perf_conflict;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_gnt0     <= '0;
      r_perf_gnt1     <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (m0_gnt) r_perf_gnt0 <= r_perf_gnt0 + PERF_W'(1);
      if (m1_gnt) r_perf_gnt1 <= r_perf_gnt1 + PERF_W'(1);
      if (m0_req && m1_req && !(m0_gnt && m1_gnt)) begin
        r_perf_conflict <= r_perf_conflict + PERF_W'(1);
      end
    end
  end

  assign perf_gnt0     = r_perf_gnt0;
  assign perf_gnt1     = r_perf_gnt1;
  assign perf_conflict = r_perf_conflict;
`else
  assign perf_gnt0     = {PERF_W{1'b0}};
  assign perf_gnt1     = {PERF_W{1'b0}};
  assign perf_conflict = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized two-master traffic
// checked against a transaction-level reference model and memory image.
module tb_ram_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          d_req[2];
  logic          d_wr[2];
  logic [3:0]    d_strb[2];
  logic [AW-1:0] d_addr[2];
  logic [DW-1:0] d_wdata[2];

  logic          m0_gnt, m1_gnt, m0_rsp_valid, m1_rsp_valid, ram_we;
  logic [DW-1:0] m0_rdata, m1_rdata, ram_d, ram_spo;
  logic [AW-1:0] ram_a;
  logic [31:0]   perf_gnt0, perf_gnt1, perf_conflict;

  logic          gnt[2];
  logic          rspv[2];
  logic [DW-1:0] rdat[2];
  assign gnt[0]  = m0_gnt;
  assign gnt[1]  = m1_gnt;
  assign rspv[0] = m0_rsp_valid;
  assign rspv[1] = m1_rsp_valid;
  assign rdat[0] = m0_rdata;
  assign rdat[1] = m1_rdata;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PERF_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(d_req[0]), .m0_wr(d_wr[0]), .m0_wstrb(d_strb[0]), .m0_addr(d_addr[0]),
    .m0_wdata(d_wdata[0]), .m0_gnt(m0_gnt), .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
    .m1_req(d_req[1]), .m1_wr(d_wr[1]), .m1_wstrb(d_strb[1]), .m1_addr(d_addr[1]),
    .m1_wdata(d_wdata[1]), .m1_gnt(m1_gnt), .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo),
    .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conflict(perf_conflict)
  );

  // RAM macro: async read, write on clk edge; preload port used only while the DUT is idle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;
  assign ram_spo = mem[ram_a];
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    else if (pl_en) mem[pl_a] <= pl_d;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    step();
    pl_en = 1'b0;
  endtask

  // One directed transaction: expected latency, cycle of the RAM write (-1 none) and read data.
  task automatic xact(input int m, input logic wr, input logic [3:0] s, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int lat, input int we_at,
                      input logic [DW-1:0] exp_rd, output int waited);
    int w;
    w = 0;
    d_req[m] = 1'b1; d_wr[m] = wr; d_strb[m] = s; d_addr[m] = a; d_wdata[m] = wd;
    @(negedge clk);
    while (!gnt[m] && w < 10) begin
      w++;
      @(negedge clk);
    end
    chk("xact_gnt", gnt[m], 1);
    waited = w;
    step();
    d_req[m] = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("xact_we", ram_we, c == we_at);
      chk("xact_rsp", rspv[m], c == lat);
      chk("xact_other_rsp", rspv[1-m], 0);
      chk("xact_other_rdata", rdat[1-m], 0);
      if (c == lat) chk("xact_rdata", rdat[m], wr ? 32'h0 : exp_rd);
    end
    step();
  endtask

  // Transaction-level reference: who should be granted, when responses and writes are due.
  logic          mon_en = 1'b0;
  int unsigned   cyc;
  logic          busy;
  logic          rr;
  logic          p_own, p_rd;
  int            p_lat, p_we;
  int unsigned   p_g;
  logic [31:0]   p_rdata;
  int unsigned   gcnt[2];
  logic [31:0]   ref_mem [0:15];

  always @(negedge clk) begin : mon
    logic e_g0, e_g1;
    int   off, m;
    logic [3:0] a;
    if (mon_en) begin
      cyc++;
      e_g0 = 1'b0; e_g1 = 1'b0;
      if (!busy) begin
        if (d_req[0] && d_req[1]) begin
          e_g1 = !rr; e_g0 = rr;
        end else begin
          e_g0 = d_req[0]; e_g1 = d_req[1];
        end
      end
      chk("rnd_gnt0", m0_gnt, e_g0);
      chk("rnd_gnt1", m1_gnt, e_g1);
      off = busy ? int'(cyc - p_g) : 0;
      chk("rnd_we", ram_we, busy && off == p_we);
      chk("rnd_rsp0", m0_rsp_valid, busy && off == p_lat && !p_own);
      chk("rnd_rsp1", m1_rsp_valid, busy && off == p_lat && p_own);
      chk("rnd_rdata0", m0_rdata, (busy && off == p_lat && !p_own && p_rd) ? p_rdata : 32'h0);
      chk("rnd_rdata1", m1_rdata, (busy && off == p_lat && p_own && p_rd) ? p_rdata : 32'h0);
      if (busy && off == p_lat) begin
        busy = 1'b0;
      end else if (e_g0 || e_g1) begin
        m = e_g1 ? 1 : 0;
        a = d_addr[m][3:0];
        busy = 1'b1; p_own = e_g1; p_g = cyc; rr = e_g1; gcnt[m]++;
        p_rd = !d_wr[m];
        p_lat = 2; p_we = -1; p_rdata = '0;
        if (p_rd) begin
          p_rdata = ref_mem[a];
        end else if (d_strb[m] == 4'hF) begin
          p_we = 1;
        end else if (d_strb[m] != 4'h0) begin
          p_lat = 3; p_we = 2;
        end
        if (!p_rd) ref_mem[a] = bmerge(ref_mem[a], d_wdata[m], d_strb[m]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, k, conf;
    int g_k[$];
    int g_m[$];
    int unsigned seen[2];
    for (int i = 0; i < 2; i++) begin
      d_req[i] = 1'b0; d_wr[i] = 1'b0; d_strb[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
      gcnt[i] = 0;
    end
    cyc = 0; busy = 1'b0; rr = 1'b0;

    // Reset state, with a request pending that must not be granted.
    d_req[0] = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_gnt0", m0_gnt, 0);
    chk("rst_gnt1", m1_gnt, 0);
    chk("rst_rsp", {m0_rsp_valid, m1_rsp_valid}, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_d", ram_d, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    chk("rst_perf", {perf_gnt0, perf_gnt1}, 0);
    step();
    d_req[0] = 1'b0;
    reset = 1'b0;
    step();

    preload(14'h10, 32'hDEADBEEF);
    xact(0, 1'b0, 4'h0, 14'h10, 32'h0, 2, -1, 32'hDEADBEEF, w);
    xact(1, 1'b1, 4'hF, 14'h20, 32'h11223344, 2, 1, 32'h0, w);
    xact(0, 1'b0, 4'h0, 14'h20, 32'h0, 2, -1, 32'h11223344, w);
    preload(14'h30, 32'hAABBCCDD);
    xact(1, 1'b1, 4'b0011, 14'h30, 32'h00001122, 3, 2, 32'h0, w);
    xact(0, 1'b0, 4'h0, 14'h30, 32'h0, 2, -1, 32'hAABB1122, w);
    xact(1, 1'b1, 4'b0000, 14'h30, 32'hFFFFFFFF, 2, -1, 32'h0, w);
    xact(1, 1'b0, 4'h0, 14'h30, 32'h0, 2, -1, 32'hAABB1122, w);

    // Reset landing in the merge-write cycle of a partial write.
    preload(14'h40, 32'h12345678);
    d_req[1] = 1'b1; d_wr[1] = 1'b1; d_strb[1] = 4'b1100; d_addr[1] = 14'h40;
    d_wdata[1] = 32'hFFFF0000;
    @(negedge clk);
    chk("rstwr_gnt", m1_gnt, 1);
    step();
    d_req[1] = 1'b0;
    @(negedge clk);
    chk("rstwr_acc_we", ram_we, 0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rstwr_we", ram_we, 0);
    chk("rstwr_rsp", m1_rsp_valid, 0);
    step();
    reset = 1'b0;
    chk("rstwr_mem", mem[14'h40], 32'h12345678);
    xact(0, 1'b0, 4'h0, 14'h40, 32'h0, 2, -1, 32'h12345678, w);
    chk("rstwr_idle_next", w, 0);

    // Both masters requesting continuously from reset.
    reset = 1'b1;
    d_req[0] = 1'b1; d_wr[0] = 1'b0; d_addr[0] = 14'h10;
    d_req[1] = 1'b1; d_wr[1] = 1'b0; d_addr[1] = 14'h20;
    step();
    reset = 1'b0;
    conf = 0;
    for (k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) begin
`ifdef ARB_PERF_CNT_EN
        chk("perf_gnt0", perf_gnt0, 2);
        chk("perf_gnt1", perf_gnt1, 2);
        chk("perf_conflict", perf_conflict, conf);
`else
        chk("perf_off", {perf_gnt0, perf_gnt1, perf_conflict}, 0);
`endif
      end else begin
        if (m0_gnt) begin g_k.push_back(k); g_m.push_back(0); end
        if (m1_gnt) begin g_k.push_back(k); g_m.push_back(1); end
        if (d_req[0] && d_req[1]) conf++;
      end
    end
    chk("conf_ngrants", g_k.size(), 4);
    for (int i = 0; i < g_k.size() && i < 4; i++) begin
      chk("conf_owner", g_m[i], (i % 2 == 0) ? 1 : 0);
      chk("conf_cycle", g_k[i], 3 * i);
    end
    step();
    d_req[0] = 1'b0; d_req[1] = 1'b0;
    repeat (4) step();

    // Randomized traffic against the reference model.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      preload(AW'(a), ref_mem[a]);
    end
    cyc = 0; busy = 1'b0; rr = 1'b0;
    seen[0] = gcnt[0]; seen[1] = gcnt[1];
    mon_en = 1'b1;
    repeat (1500) begin
      for (int m = 0; m < 2; m++) begin
        if (gcnt[m] != seen[m]) begin
          seen[m] = gcnt[m];
          d_req[m] = 1'b0;
        end
        if (!d_req[m] && $urandom_range(3) != 0) begin
          d_req[m] = 1'b1;
          d_wr[m] = 1'($urandom_range(1));
          k = $urandom_range(3);
          d_strb[m] = (k == 0) ? 4'h0 : (k == 1) ? 4'hF : 4'($urandom_range(14, 1));
          d_addr[m] = AW'($urandom_range(15));
          d_wdata[m] = $urandom;
        end
      end
      step();
    end
    k = 0;
    while ((d_req[0] || d_req[1] || busy) && k < 40) begin
      for (int m = 0; m < 2; m++) begin
        if (gcnt[m] != seen[m]) begin
          seen[m] = gcnt[m];
          d_req[m] = 1'b0;
        end
      end
      k++;
      step();
    end
    chk("rnd_drain", k < 40, 1);
    mon_en = 1'b0;
    for (int a = 0; a < 16; a++) chk("rnd_mem", mem[a], ref_mem[a]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
